// File: rtl/sine_monitor.sv
// ---------------------------------------------------------------------------
// sine_monitor
//   Receive-side self-check for the sine DAC path. Watches a parallel sample
//   stream, detects midscale rising crossings with hysteresis, tracks the
//   per-cycle minimum and maximum, and measures the waveform period in clk
//   cycles. Each completed cycle is reported with a one-cycle strobe.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   sample_in     unsigned sample, qualified by sample_valid
//   sample_valid  one-cycle qualifier per sample
//   period        clk cycles between the last two accepted rising crossings
//   max_val       largest sample in the last measured cycle
//   min_val       smallest sample in the last measured cycle
//   meas_valid    one-cycle pulse when period/max_val/min_val update
//   locked        high while crossings keep arriving before counter saturation
// ---------------------------------------------------------------------------
module sine_monitor #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned HYST  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [CNT_W-1:0] period,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic             meas_valid,
  output logic             locked
);

  // Thresholds live at WIDTH+1 bits so MID+HYST cannot wrap; a HYST larger
  // than MID disables the low threshold instead of wrapping it.
  localparam int unsigned MID     = 2 ** (WIDTH - 1);
  localparam int unsigned HI_TH_I = MID + HYST;
  localparam bit          LO_EN   = (HYST <= MID);
  localparam int unsigned LO_TH_I = LO_EN ? (MID - HYST) : 32'd0;

  localparam logic [WIDTH:0]   HI_TH   = (WIDTH + 1)'(HI_TH_I);
  localparam logic [WIDTH:0]   LO_TH   = (WIDTH + 1)'(LO_TH_I);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] max_val_q, max_val_d;
  logic [WIDTH-1:0] min_val_q, min_val_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;

  logic [WIDTH:0]   sample_ext;
  logic             low_hit;
  logic             high_hit;
  logic             crossing;
  logic [WIDTH-1:0] upd_max;
  logic [WIDTH-1:0] upd_min;

  // Threshold detection on accepted samples only
  assign sample_ext = {1'b0, sample_in};
  assign low_hit    = sample_valid && LO_EN && (sample_ext <= LO_TH);
  assign high_hit   = sample_valid && (sample_ext >= HI_TH);
  assign crossing   = high_hit && armed_q;

  // Running extremes including the current sample (unsigned compare)
  assign upd_max = (sample_in > run_max_q) ? sample_in : run_max_q;
  assign upd_min = (sample_in < run_min_q) ? sample_in : run_min_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARM;
      count_q      <= '0;
      run_min_q    <= '0;
      run_max_q    <= '0;
      armed_q      <= 1'b0;
      period_q     <= '0;
      max_val_q    <= '0;
      min_val_q    <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      armed_q      <= armed_d;
      period_q     <= period_d;
      max_val_q    <= max_val_d;
      min_val_q    <= min_val_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    armed_d      = armed_q;
    period_d     = period_q;
    max_val_d    = max_val_q;
    min_val_d    = min_val_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;

    if (crossing) begin
      armed_d = 1'b0;
    end else if (low_hit) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      ARM: begin
        if (crossing) begin
          state_d   = MEASURE;
          count_d   = CNT_ONE;
          run_min_d = sample_in;
          run_max_d = sample_in;
        end
      end

      MEASURE: begin
        if (crossing) begin
          // Crossing sample closes this cycle and opens the next; it also
          // wins over saturation, reporting a period of CNT_MAX.
          period_d     = count_q;
          max_val_d    = upd_max;
          min_val_d    = upd_min;
          meas_valid_d = 1'b1;
          locked_d     = 1'b1;
          count_d      = CNT_ONE;
          run_min_d    = sample_in;
          run_max_d    = sample_in;
        end else if (count_q == CNT_MAX) begin
          // Lost the waveform: drop lock, keep last reported measurement
          state_d  = ARM;
          armed_d  = 1'b0;
          locked_d = 1'b0;
          count_d  = '0;
        end else begin
          count_d = count_q + CNT_ONE;
          if (sample_valid) begin
            run_min_d = upd_min;
            run_max_d = upd_max;
          end
        end
      end

      default: begin
        state_d = ARM;
      end
    endcase
  end

  assign period     = period_q;
  assign max_val    = max_val_q;
  assign min_val    = min_val_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_sine_monitor.sv
// ---------------------------------------------------------------------------
// tb_sine_monitor
//   Directed bench for sine_monitor. Two instances share the input stream:
//   dut (CNT_W=24) for normal measurement, dut8 (CNT_W=8) for saturation.
// ---------------------------------------------------------------------------
module tb_sine_monitor;

  localparam int unsigned WIDTH = 10;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;

  logic [23:0]      period;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic             meas_valid;
  logic             locked;

  logic [7:0]       period8;
  logic [WIDTH-1:0] max8;
  logic [WIDTH-1:0] min8;
  logic             meas8;
  logic             locked8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int n_p, first_p, last_p;
  int n_p8, last_p8, fall8;
  logic lock8_prev;
  bit chk_main, chk8;
  int exp_period, exp_max, exp_min;
  int c;

  sine_monitor #(.WIDTH(10), .CNT_W(24), .HYST(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period       (period),
    .max_val      (max_val),
    .min_val      (min_val),
    .meas_valid   (meas_valid),
    .locked       (locked)
  );

  sine_monitor #(.WIDTH(10), .CNT_W(8), .HYST(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period       (period8),
    .max_val      (max8),
    .min_val      (min8),
    .meas_valid   (meas8),
    .locked       (locked8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample i of a cosine-phased sine starting at its minimum
  function automatic logic [WIDTH-1:0] wave(input int i, input int n,
                                            input real ctr, input real amp);
    real x;
    x = ctr - amp * $cos(2.0 * 3.14159265358979 * real'(i % n) / real'(n)) + 0.5;
    return WIDTH'($rtoi(x));
  endfunction

  // Index of the first rising crossing (thresholds 504 / 520) in one period
  function automatic int first_cross(input int n, input real ctr, input real amp);
    bit armed;
    int v;
    armed = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = int'(wave(i, n, ctr, amp));
      if (armed && v >= 520) return i;
      if (v <= 504) armed = 1'b1;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] sq(input int j);
    return (((j / 100) % 2) == 1) ? 10'd1023 : 10'd0;
  endfunction

  // One clock: observe outputs of the previous edge, then drive the next sample
  task automatic tick(input logic [WIDTH-1:0] s, input logic v);
    @(negedge clk);
    if (meas_valid) begin
      n_p++;
      if (first_p < 0) first_p = cyc;
      else if (chk_main) check("spacing", cyc - last_p, exp_period);
      last_p = cyc;
      if (chk_main) begin
        check("period", int'(period), exp_period);
        check("max_val", int'(max_val), exp_max);
        check("min_val", int'(min_val), exp_min);
        check("locked_at_pulse", int'(locked), 1);
      end
    end
    if (meas8) begin
      n_p8++;
      last_p8 = cyc;
      if (chk8) begin
        check("period8", int'(period8), exp_period);
        check("max8", int'(max8), exp_max);
        check("min8", int'(min8), exp_min);
        check("locked8_at_pulse", int'(locked8), 1);
      end
    end
    if (lock8_prev && !locked8 && fall8 < 0) fall8 = cyc;
    lock8_prev   = locked8;
    sample_in    = s;
    sample_valid = v;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_period", int'(period), 0);
    check("rst_max", int'(max_val), 0);
    check("rst_min", int'(min_val), 0);
    check("rst_meas", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_period8", int'(period8), 0);
    check("rst_locked8", int'(locked8), 0);
    cyc = 0; n_p = 0; first_p = -1; last_p = -1;
    n_p8 = 0; last_p8 = -1; fall8 = -1; lock8_prev = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample_in = '0; sample_valid = 1'b0;
    chk_main = 1'b0; chk8 = 1'b0;
    exp_period = 0; exp_max = 0; exp_min = 0;

    // 1: full-scale sine, 256 samples/period, valid every cycle
    do_reset();
    chk_main = 1'b1; exp_period = 256; exp_max = 1023; exp_min = 0;
    c = first_cross(256, 511.5, 511.5);
    for (int t = 0; t < 1280; t++) tick(wave(t, 256, 511.5, 511.5), 1'b1);
    check("t1_pulses", n_p, 4);
    check("t1_first", first_p, c + 257);
    check("t1_locked", int'(locked), 1);

    // 2: 64 samples/period, one valid every 4th cycle
    do_reset();
    c = first_cross(64, 511.5, 511.5);
    for (int t = 0; t < 1280; t++) tick(wave(t / 4, 64, 511.5, 511.5), (t % 4) == 0);
    check("t2_pulses", n_p, 4);
    check("t2_first", first_p, 4 * c + 257);
    check("t2_period", int'(period), 256);

    // 3a: square wave 100 low / 100 high
    do_reset();
    exp_period = 200; exp_max = 1023; exp_min = 0;
    for (int j = 0; j < 600; j++) tick(sq(j), 1'b1);
    check("t3a_pulses", n_p, 2);
    check("t3a_first", first_p, 301);

    // 3b: reduced-amplitude sine 312..712, 128 samples/period
    do_reset();
    exp_period = 128; exp_max = 712; exp_min = 312;
    c = first_cross(128, 512.0, 200.0);
    for (int t = 0; t < 384; t++) tick(wave(t, 128, 512.0, 200.0), 1'b1);
    check("t3b_pulses", n_p, 2);
    check("t3b_first", first_p, c + 129);
    check("t3b_max", int'(max_val), 712);
    check("t3b_min", int'(min_val), 312);

    // 4: noise inside the hysteresis band never arms
    do_reset();
    for (int t = 0; t < 10000; t++) tick(WIDTH'($urandom_range(517, 507)), 1'b1);
    check("t4_pulses", n_p, 0);
    check("t4_locked", int'(locked), 0);
    check("t4_period", int'(period), 0);
    check("t4_max", int'(max_val), 0);
    check("t4_min", int'(min_val), 0);

    // 6: reset mid-period while locked, then relock from scratch
    do_reset();
    exp_period = 200; exp_max = 1023; exp_min = 0;
    for (int j = 0; j < 450; j++) tick(sq(j), 1'b1);
    check("t6_locked_before", int'(locked), 1);
    check("t6_pulses_before", n_p, 1);
    do_reset();
    for (int j = 0; j < 400; j++) tick(sq(j), 1'b1);
    check("t6_pulses_after", n_p, 1);
    check("t6_first_after", first_p, 301);
    check("t6_period_after", int'(period), 200);

    // 5: CNT_W=8 saturation, then recovery
    do_reset();
    chk_main = 1'b0; chk8 = 1'b1;
    for (int j = 0; j < 1100; j++) begin
      if (j == 700) begin
        check("t5_pulses_hold", n_p8, 1);
        check("t5_fall", fall8, 556);
        check("t5_locked_hold", int'(locked8), 0);
        check("t5_period_hold", int'(period8), 200);
        check("t5_max_hold", int'(max8), 1023);
      end
      if (j < 400) tick(sq(j), 1'b1);
      else if (j < 700) tick(10'd1023, 1'b1);
      else tick(sq(j - 700), 1'b1);
    end
    check("t5_pulses_relock", n_p8, 2);
    check("t5_last_relock", last_p8, 1001);
    check("t5_locked_relock", int'(locked8), 1);
    check("t5_period_relock", int'(period8), 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_monitor.md
Name: sine_monitor

Overview:
- Receive-side companion to the sine DAC output block.
- Takes a parallel WIDTH-bit sample stream from the external ADC, or from the DAC pins looped back.
- Detects midscale rising crossings with hysteresis, and tracks the per-cycle minimum and maximum.
- Measures the waveform period in clk cycles and reports each completed cycle with a one-cycle strobe.
- Used for on-board self-check of the sine generator.

Parameters:
- WIDTH, 10, sample width in bits.
- CNT_W, 24, period counter width.
- HYST, 8, hysteresis in LSBs around midscale; MID = 2**(WIDTH-1).

Ports:
- clk  input  1  system clock (12 MHz board clock).
- rst  input  1  synchronous reset, active-high.
- sample_in  input  WIDTH  unsigned sample, synchronous to clk; valid only when sample_valid=1.
- sample_valid  input  1  one-cycle qualifier per sample; may be high every cycle.
- period  output  CNT_W  clk cycles between the last two accepted rising crossings.
- max_val  output  WIDTH  largest sample in the last measured cycle.
- min_val  output  WIDTH  smallest sample in the last measured cycle.
- meas_valid  output  1  one-cycle pulse when period/max_val/min_val update.
- locked  output  1  high while consecutive crossings arrive without counter saturation.

Behaviour:
- Reset (rst=1 at posedge): state=ARM; all outputs 0; internal count, run_min, run_max and the armed flag all cleared. rst has priority over everything and is honoured mid-measurement; no meas_valid in the reset cycle or the cycle after.
- Samples are considered only when sample_valid=1. Other cycles only advance the counter.
- Armed flag: set when an accepted sample <= MID-HYST. Cleared when a rising crossing is taken.
- Rising crossing: an accepted sample >= MID+HYST while armed=1. Samples between the two thresholds change nothing.
- States:
  - ARM: waits for the first rising crossing. On crossing: count=1, run_min=run_max=crossing sample, go to MEASURE.
  - MEASURE:
    - count increments every clk cycle, valid or not.
    - Each accepted sample updates run_min/run_max using unsigned compare.
    - On a rising crossing: on the next cycle, period=count, max_val=run_max, min_val=run_min, meas_valid=1 and locked=1. Then count restarts at 1 and run_min/run_max reload from the crossing sample. Stay in MEASURE, so back-to-back cycles are measured with no gap.
    - The crossing sample belongs to both cycles: it is the last sample compared in the closing cycle and the first in the new one.
- Latency: meas_valid rises exactly 1 clk after the posedge that accepted the closing crossing sample. The registered outputs hold until the next meas_valid or reset.
- Saturation: if count reaches 2**CNT_W-1 in MEASURE:
  - go to ARM and clear the armed flag;
  - locked=0, meas_valid stays 0;
  - period/max_val/min_val keep their old values.
- Crossing and saturation in the same cycle: the crossing wins, and the measurement reports period=2**CNT_W-1.
- Width rules: thresholds are computed at WIDTH+1 bits so HYST near MID cannot wrap. count never wraps.

Test Plan:
1. Full-scale sine (0..1023, 256 samples/period), sample_valid=1 every cycle, run 4 periods -> first meas_valid 1 cycle after the second crossing. Each pulse: period=256, max_val=1023, min_val=0, locked=1. Pulses spaced 256 cycles apart.
2. Same sine at 64 samples/period with sample_valid every 4th cycle -> period=256, max_val=1023, min_val=0, locked=1.
3. Square wave 100 cycles at 0 then 100 cycles at 1023, repeating -> period=200, max_val=1023, min_val=0. A sine between 312 and 712 -> max_val=712, min_val=312.
4. Noise at 512±5 with HYST=8 for 10000 cycles -> meas_valid never asserts, locked=0, outputs stay 0.
5. CNT_W=8: lock on a 200-cycle square wave, then hold input at 1023 -> locked falls 255 cycles after the last crossing, no meas_valid, period still 200. Resume the square wave -> relocks after two crossings.
6. rst pulsed for 1 cycle mid-period while locked -> next cycle all outputs 0 and state ARM. The first meas_valid comes only after two new crossings, with the correct period.
